// File: rtl/chan_packer.sv
// Multi-channel sample packer: serialises enabled channels (optionally behind an
// A5 5A <frame#> header) into sign-extended big-endian bytes and buffers them in a byte FIFO.
module chan_packer #(
  parameter int NCHAN = 2,
  parameter int OW    = 14,
  parameter int USBDW = 8,
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NCHAN*OW-1:0]      data_i,
  input  logic                     valid_i,
  input  logic                     frame_start_i,
  input  logic [NCHAN-1:0]         chan_en_i,
  output logic [USBDW-1:0]         wdata_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int SB = (OW + 7) / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int BW = (SB > 1) ? $clog2(SB) : 1;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [BW-1:0] LAST_B   = BW'(SB - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state;
  logic [NCHAN*OW-1:0] data_q;
  logic [NCHAN-1:0]    mask_q;
  logic [1:0]          hdr_idx;
  logic [CW-1:0]       chan;
  logic [BW-1:0]       bidx;
  logic [7:0]          frame_cnt;

  logic [USBDW-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_next;
  logic [AW:0]         remaining;

  logic [USBDW-1:0]    ser_byte;
  logic [OW-1:0]       cur_sample;
  logic [CW:0]         nxt_ch, hdr_first, new_first;
  logic                push, pop, last_byte, accept_ok;

  // Lowest enabled channel at or above start; MSB flags that one was found.
  function automatic logic [CW:0] first_from(input logic [NCHAN-1:0] m, input int start);
    logic [CW:0] r;
    r = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (k >= start && m[k]) r = {1'b1, CW'(k)};
    end
    return r;
  endfunction

  function automatic logic [7:0] sample_byte(input logic [OW-1:0] s, input int b);
    logic [SB*8-1:0] e;
    e = {(SB*8){s[OW-1]}};
    e[OW-1:0] = s;
    return e[(SB-1-b)*8 +: 8];
  endfunction

  assign cur_sample = data_q[int'(chan)*OW +: OW];
  assign nxt_ch     = first_from(mask_q, int'(chan) + 1);
  assign hdr_first  = first_from(mask_q, 0);
  assign new_first  = first_from(chan_en_i, 0);
  assign push       = (state != IDLE) && (count_o != FULL_CNT);
  assign pop        = wvalid_o && wready_i;
  assign accept_ok  = (state == IDLE) || (push && last_byte);
  assign rd_next    = rd_ptr + (pop ? PTR_ONE : '0);
  assign remaining  = count_o - (pop ? CNT_ONE : '0);

  // Byte currently offered by the serializer and whether it ends the set.
  always_comb begin
    ser_byte  = '0;
    last_byte = 1'b0;
    case (state)
      HDR: begin
        case (hdr_idx)
          2'd0:    ser_byte = 8'hA5;
          2'd1:    ser_byte = 8'h5A;
          default: ser_byte = frame_cnt;
        endcase
        last_byte = (hdr_idx == 2'd2) && !hdr_first[CW];
      end
      DATA: begin
        ser_byte  = sample_byte(cur_sample, int'(bidx));
        last_byte = (bidx == LAST_B) && !nxt_ch[CW];
      end
      default: begin
        ser_byte  = '0;
        last_byte = 1'b0;
      end
    endcase
  end

  // Serializer FSM, capture and overflow flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      hdr_idx    <= 2'd0;
      chan       <= '0;
      bidx       <= '0;
      frame_cnt  <= 8'd0;
      overflow_o <= 1'b0;
    end else begin
      if (valid_i && !accept_ok) overflow_o <= 1'b1;
      if (push && state == HDR && hdr_idx == 2'd2) frame_cnt <= frame_cnt + 8'd1;
      if (valid_i && accept_ok && (frame_start_i || (|chan_en_i))) begin
        data_q  <= data_i;
        mask_q  <= chan_en_i;
        hdr_idx <= 2'd0;
        bidx    <= '0;
        chan    <= new_first[CW-1:0];
        state   <= frame_start_i ? HDR : DATA;
      end else if (push) begin
        case (state)
          HDR: begin
            if (hdr_idx == 2'd2) begin
              chan  <= hdr_first[CW-1:0];
              bidx  <= '0;
              state <= hdr_first[CW] ? DATA : IDLE;
            end else begin
              hdr_idx <= hdr_idx + 2'd1;
            end
          end
          DATA: begin
            if (bidx == LAST_B) begin
              chan  <= nxt_ch[CW-1:0];
              bidx  <= '0;
              state <= nxt_ch[CW] ? DATA : IDLE;
            end else begin
              bidx <= bidx + BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= ser_byte;
  end

  // FIFO pointers, fill level and registered head byte (lags a push by one cycle).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_o  <= '0;
      wvalid_o <= 1'b0;
      wdata_o  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count_o <= count_o + CNT_ONE;
        2'b01:   count_o <= count_o - CNT_ONE;
        default: count_o <= count_o;
      endcase
      wvalid_o <= (remaining != '0);
      if ((remaining != '0) && (pop || !wvalid_o)) wdata_o <= mem[rd_next];
    end
  end

endmodule

// File: tb/tb_chan_packer.sv
// Randomised and directed bench for chan_packer against a queue-based byte model.
module tb_chan_packer;
  localparam int NCHAN = 2;
  localparam int OW    = 14;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCHAN*OW-1:0] data = '0;
  logic                valid = 1'b0;
  logic                fs = 1'b0;
  logic [NCHAN-1:0]    mask = '0;
  logic [7:0]          wdata;
  logic                wvalid;
  logic                wready = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                ovf;

  always #5 clk = ~clk;

  chan_packer #(.NCHAN(NCHAN), .OW(OW), .USBDW(8), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .frame_start_i(fs), .chan_en_i(mask), .wdata_o(wdata), .wvalid_o(wvalid),
    .wready_i(wready), .count_o(count), .overflow_o(ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ser_q[$];
  logic [7:0] fq[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic       mv;
  logic [7:0] mdata;
  logic       movf;
  logic [7:0] mfc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    ser_q.delete();
    fq.delete();
    mv = 1'b0; mdata = 8'h00; movf = 1'b0; mfc = 8'h00;
  endtask

  // One clock edge of the reference: bytes of a set queue up, move to the FIFO one per cycle.
  task automatic model_edge();
    bit do_pop, do_push, busy;
    int rem, sv;
    logic [OW-1:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    do_pop  = mv && wready;
    do_push = (ser_q.size() > 0) && (fq.size() < DEPTH);
    busy    = (ser_q.size() > 1) || (ser_q.size() == 1 && !do_push);
    rem     = fq.size() - (do_pop ? 1 : 0);
    if (do_pop) void'(fq.pop_front());
    if (rem > 0 && (do_pop || !mv)) mdata = fq[0];
    mv = (rem > 0);
    if (do_push) fq.push_back(ser_q.pop_front());
    if (valid) begin
      if (busy) movf = 1'b1;
      else begin
        if (fs) begin
          ser_q.push_back(8'hA5); ser_q.push_back(8'h5A); ser_q.push_back(mfc);
          mfc = mfc + 8'd1;
        end
        for (int ch = 0; ch < NCHAN; ch++) begin
          if (mask[ch]) begin
            s  = data[ch*OW +: OW];
            sv = $signed(s);
            ser_q.push_back(sv[15:8]);
            ser_q.push_back(sv[7:0]);
          end
        end
      end
    end
  endtask

  task automatic step();
    if (wvalid && wready) got.push_back(wdata);
    @(posedge clk);
    model_edge();
    #1;
    check("count", count, fq.size());
    check("wvalid", wvalid, mv);
    check("overflow", ovf, movf);
    if (mv) check("wdata", wdata, mdata);
  endtask

  task automatic send(input logic f, input logic [1:0] m, input logic [13:0] d0, input logic [13:0] d1);
    valid = 1'b1; fs = f; mask = m; data = {d1, d0};
    step();
    valid = 1'b0; fs = 1'b0;
  endtask

  task automatic drain();
    wready = 1'b1;
    valid  = 1'b0;
    for (int i = 0; i < 200 && (ser_q.size() > 0 || fq.size() > 0 || mv); i++) step();
    step();
    check("drain_empty", count, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !(ser_q.size() == 0 || (ser_q.size() == 1 && fq.size() < DEPTH)); i++) step();
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; wready = 1'b0;
    model_reset();
    step();
    step();
    check("rst_count", count, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wdata", wdata, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    got.delete();
  endtask

  initial begin
    do_reset();

    // Header plus two channels
    send(1'b1, 2'b11, 14'h1234, 14'h2001);
    drain();
    exp_q = {8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hE0, 8'h01};
    check_seq("hdr2ch");
    check("hdr2ch_ovf", ovf, 0);

    // Single-channel mask, then empty mask
    got.delete();
    send(1'b0, 2'b10, 14'h0000, 14'h0005);
    drain();
    exp_q = {8'h00, 8'h05};
    check_seq("ch1only");
    got.delete();
    send(1'b0, 2'b00, 14'h1111, 14'h2222);
    drain();
    check("mask0_len", got.size(), 0);
    check("mask0_ovf", ovf, 0);

    // Overflow on consecutive strobes
    got.delete();
    valid = 1'b1; mask = 2'b11; fs = 1'b0; data = {14'h0100, 14'h3FFF};
    step();
    data = {14'h0AAA, 14'h0555};
    step();
    valid = 1'b0;
    drain();
    exp_q = {8'hFF, 8'hFF, 8'h01, 8'h00};
    check_seq("ovf_first");
    check("ovf_set", ovf, 1);
    for (int i = 0; i < 5; i++) step();
    check("ovf_sticky", ovf, 1);
    do_reset();

    // Backpressure into a full FIFO
    wready = 1'b0;
    send(1'b1, 2'b11, 14'h1234, 14'h2001);
    wait_idle();
    send(1'b1, 2'b11, 14'h1234, 14'h2001);
    for (int i = 0; i < 10; i++) step();
    check("bp_full", count, 8);
    check("bp_no_ovf_yet", ovf, 0);
    send(1'b1, 2'b11, 14'h0777, 14'h0666);
    check("bp_drop", ovf, 1);
    drain();
    exp_q = {8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hE0, 8'h01,
             8'hA5, 8'h5A, 8'h01, 8'h12, 8'h34, 8'hE0, 8'h01};
    check_seq("bp_order");
    do_reset();

    // Frame counter wrap
    for (int i = 0; i < 257; i++) begin
      got.delete();
      send(1'b1, 2'b00, 14'h0000, 14'h0000);
      drain();
      check("wrap_len", got.size(), 3);
      if (got.size() >= 3) check("wrap_fc", got[2], i & 255);
    end

    // Asynchronous reset in the middle of a frame
    got.delete();
    wready = 1'b1;
    send(1'b1, 2'b11, 14'h1234, 14'h2001);
    send(1'b0, 2'b01, 14'h0001, 14'h0000);
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_count", count, 0);
    check("amid_wvalid", wvalid, 0);
    check("amid_wdata", wdata, 0);
    check("amid_ovf", ovf, 0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    got.delete();
    send(1'b1, 2'b00, 14'h0000, 14'h0000);
    drain();
    exp_q = {8'hA5, 8'h5A, 8'h00};
    check_seq("post_rst");

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      valid  = ($urandom_range(0, 2) == 0);
      fs     = ($urandom_range(0, 3) == 0);
      mask   = 2'($urandom_range(0, 3));
      data   = 28'($urandom());
      wready = ($urandom_range(0, 3) != 0);
      step();
    end
    valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/chan_packer.md
# chan_packer

Parametrised multi-channel sample packer between the per-channel filter/downsample/window chains and the FT2232H `usb` block. It generalises the two-channel data packer to NCHAN channels with a runtime channel-enable mask. On each sample set it serialises the enabled channels into sign-extended big-endian bytes, optionally preceded by a frame header, and buffers them in a byte FIFO. The FIFO drains through a valid/ready handshake and applies backpressure without losing bytes.

## Interface
- `NCHAN`, 2, number of input channels (1-8)
- `OW`, 14, bits per sample, signed two's complement (2-32)
- `USBDW`, 8, output byte width; fixed at 8
- `DEPTH`, 512, FIFO depth in bytes; power of two, at least 8
- `SB`, derived: ceil(OW/8), bytes per sample

- `clk_i`  in  1  single clock; all logic is on its rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `data_i`  in  NCHAN*OW  sample set; channel k occupies bits [k*OW +: OW]
- `valid_i`  in  1  one-cycle strobe; data_i holds a new set
- `frame_start_i`  in  1  qualified by valid_i; this set begins a ramp and gets a header
- `chan_en_i`  in  NCHAN  channel-enable mask, sampled with valid_i
- `wdata_o`  out  8  FIFO head byte
- `wvalid_o`  out  1  FIFO not empty
- `wready_i`  in  1  consumer accepts wdata_o this cycle
- `count_o`  out  $clog2(DEPTH)+1  FIFO fill level in bytes
- `overflow_o`  out  1  sticky; a sample set was dropped

## Operation
- **Capture:** on valid_i=1 with the serializer idle, latch data_i, frame_start_i and chan_en_i.
  - If chan_en_i==0 and frame_start_i==0, the set is ignored: no bytes and no overflow.
  - If valid_i=1 while busy, the set is dropped and overflow_o is set. Only reset clears overflow_o.
- **Serializer FSM:** IDLE -> HDR (if frame_start) or DATA -> IDLE.
  - HDR emits 8'hA5, 8'h5A, then the frame counter. The counter is 8 bits, increments after emission, wraps 255->0, and resets to 0.
  - DATA walks enabled channels in ascending index. Each sample is sign-extended to SB*8 bits and emitted MSB byte first. Disabled channels are skipped with no wasted cycles.
  - After the last DATA byte the FSM returns to IDLE. A set with frame_start=1 and mask 0 emits the header only.
- **Push:** one byte per cycle, only when the FIFO is not full in that cycle. A simultaneous pop does not free space for a same-cycle push. If the FIFO is full, the serializer stalls holding its byte; no byte is ever lost.
- **Pop:** occurs when wvalid_o && wready_i. wready_i is ignored while empty.
- Byte order out of the FIFO equals push order.
- **Reset (any time, including mid-frame):**
  - FSM returns to IDLE.
  - FIFO is emptied.
  - Frame counter returns to 0.
  - Outputs go to wdata_o=0, wvalid_o=0, count_o=0, overflow_o=0.

## Timing
- valid_i sampled at edge E. First byte is pushed at edge E+1. The FIFO read is registered, so wvalid_o and wdata_o present it after edge E+2.
- With no stall, bytes per set = 3*frame_start + popcount(mask)*SB. One byte is pushed per cycle.
- The serializer is idle again in the cycle of its last push, so a valid_i in that cycle is accepted. Back-to-back sets are possible at one set per N cycles, where N = bytes per set.
- count_o updates on the edge of each push or pop. A simultaneous push and pop leaves it unchanged.
- wdata_o changes only on a pop, or when the FIFO goes from empty to non-empty.

## Test plan
- **Header plus two channels:** reset, then valid_i with frame_start=1, mask=2'b11, ch0=14'h1234, ch1=14'h2001, wready_i=1. Required output: A5 5A 00 12 34 E0 01; overflow_o=0.
- **Single-channel mask:** mask=2'b10, frame_start=0, ch1=14'h0005. Required output: exactly 00 05. Mask 2'b00 with no frame_start produces no bytes.
- **Overflow:** valid_i high on two consecutive cycles, mask=2'b11. The first set is emitted intact, the second is dropped, and overflow_o=1 stays high until rst_n_i is asserted.
- **Backpressure:** DEPTH=8, wready_i=0, feed 3 header+2-channel sets. Required: count_o saturates at 8, the serializer stalls, and the third set is dropped and flagged. Then raise wready_i; all emitted bytes must come out in order with none missing or duplicated.
- **Counter wrap:** 257 frame_start sets. The third header byte runs 00..FF, then 00 on the 257th.
- **Reset mid-frame:** assert rst_n_i during DATA, asynchronously between edges. All outputs read 0 before the next edge. After release, the next frame_start set produces A5 5A 00.
